ir_conv_reader: RTL
===================

Name: ir_conv_reader

Overview:
- Read-side sequencer and multiply-accumulate engine for the 4-bank impulse-response (IR) store.
- On each audio sample strobe, it sweeps every index pair across all banks and multiplies each returned IR tap by the matching audio-history sample.
- It accumulates the full 24000-tap dot product and emits one saturated 16-bit convolution output.
- It sits between the IR store / history store (address consumers, data producers) and the audio output path.

Parameters:
- MEMORY_DEPTH, 6000, words per bank; must be even; 4 banks give 4*MEMORY_DEPTH taps.
- READ_LATENCY, 2, cycles from index presented to ir_vals/hist_vals valid.
- OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before saturation (Q15 IR).

Ports:
- audio_clk  in  1  system clock.
- rst_in  in  1  synchronous, active-high reset.
- start_in  in  1  one-cycle pulse requesting a new convolution output.
- ir_loading_in  in  1  high while the IR store is being written; blocks and aborts reads.
- first_ir_index  out  13  even index, presented to port A of every bank.
- second_ir_index  out  13  odd index, presented to port B of every bank.
- ir_vals  in  8x16 signed  lanes 0..7 = bank0 A, bank0 B, bank1 A, ..., bank3 B.
- hist_vals  in  8x16 signed  history samples, lane-aligned with ir_vals, same latency.
- conv_out  out  16 signed  saturated result; held until the next result.
- conv_valid_out  out  1  one-cycle pulse when conv_out updates.
- busy_out  out  1  high from start acceptance until the valid cycle or abort.
- overrun_out  out  1  one-cycle pulse when start_in arrives while busy.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; all outputs go to 0; accumulator, product registers and valid pipeline are cleared.
  - Reset mid-sweep discards all work, with no valid pulse.
- Terms: N = MEMORY_DEPTH/2 = 3000. Cycle 0 is the cycle in which start_in is sampled high while in IDLE with ir_loading_in low.
- States: IDLE, SWEEP, DRAIN, OUTPUT.
- IDLE:
  - Index outputs are 0.
  - On start_in with ir_loading_in low: clear accumulator, set k=0, go to SWEEP, busy_out=1 from cycle 1.
  - start_in while ir_loading_in is high is ignored silently.
- SWEEP (cycles 1..N):
  - Cycle k+1 drives first_ir_index=2k, second_ir_index=2k+1.
  - A tag bit enters a READ_LATENCY-deep valid shift register.
  - After k=N-1 (indices 5998/5999) go to DRAIN; index outputs return to 0.
- Data pipeline:
  - Data for pair k is valid at cycle k+1+READ_LATENCY.
  - 8 signed 16x16 products (32-bit) are registered one cycle later.
  - The 8-way sum is added into a 48-bit signed accumulator the following cycle.
  - Only tagged cycles contribute.
- DRAIN: wait until the last tagged sum is in the accumulator (cycle N+READ_LATENCY+2), then go to OUTPUT.
- OUTPUT (cycle N+READ_LATENCY+3 = 3005 at defaults):
  - conv_out = sat16(acc >>> OUT_SHIFT); conv_valid_out pulses; busy_out drops.
  - Return to IDLE; a start_in in this cycle is treated as busy (overrun).
- Saturation: values above 32767 give 32767; values below -32768 give -32768; arithmetic shift preserves sign.
- Overrun:
  - start_in while busy_out is high is ignored and pulses overrun_out the next cycle.
  - The current computation is unaffected.
- Abort:
  - ir_loading_in high in SWEEP/DRAIN/OUTPUT goes to IDLE next cycle.
  - Valid pipeline and accumulator are cleared; no conv_valid_out; conv_out keeps its previous value; busy_out low next cycle.
- Index outputs never exceed MEMORY_DEPTH-1.
- No bank-write interaction: this block never drives write enables.

Test Plan:
- All ir_vals=1, hist_vals=1, OUT_SHIFT=0, model with READ_LATENCY=2:
  - Pulse start -> conv_valid_out exactly 3005 cycles later, conv_out=24000, busy_out high cycles 1..3004.
- Index sweep:
  - Monitor indices -> cycle 1 gives 0/1, cycle 3000 gives 5998/5999, strictly stepping by 2.
  - Indices are 0 in IDLE/DRAIN.
- Saturation with OUT_SHIFT=0:
  - ir=32767, hist=32767 -> conv_out=32767.
  - ir=-32768, hist=32767 -> conv_out=-32768.
  - OUT_SHIFT=4 with all-ones -> conv_out=1500.
- Lane alignment:
  - Only lane 5 nonzero (ir=2, hist=3) when first_ir_index=10 was issued, all else 0, OUT_SHIFT=0 -> conv_out=6.
- Overrun:
  - start at cycle 0 and again at cycle 500 -> overrun_out pulse at cycle 501, single conv_valid_out at 3005 with the correct value.
- Abort/reset:
  - ir_loading_in high at cycle 100 -> busy_out low at 101, no valid, conv_out unchanged.
  - rst_in at cycle 200 of a new run -> all outputs 0.
  - A following start yields the correct result.

Source files
------------

// File: rtl/ir_conv_reader.sv
// ir_conv_reader: read sequencer and MAC engine for the 4-bank IR store.
// Each accepted start sweeps every even/odd index pair across all banks,
// multiplies the 8 returned IR taps by the lane-aligned history samples and
// accumulates the full dot product. The result is shifted, saturated to
// 16 bits and presented on conv_out with a one-cycle conv_valid_out pulse.
//
// Lane order on ir_vals / hist_vals: 0..7 = bank0 A, bank0 B, bank1 A, ...,
// bank3 B. Lanes are carried as packed 16-bit words and treated as signed.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for start_in; index outputs parked at 0
// SWEEP   | presenting pair k (2k / 2k+1), one pair per cycle
// DRAIN   | reads done; waiting for in-flight taps to reach the accumulator
// OUTPUT  | conv_out/conv_valid_out updated this cycle; back to IDLE next

module ir_conv_reader #(
    parameter int MEMORY_DEPTH = 6000,
    parameter int READ_LATENCY = 2,
    parameter int OUT_SHIFT    = 15
) (
    input  logic               audio_clk,
    input  logic               rst_in,
    input  logic               start_in,
    input  logic               ir_loading_in,
    output logic [12:0]        first_ir_index,
    output logic [12:0]        second_ir_index,
    input  logic [7:0][15:0]   ir_vals,
    input  logic [7:0][15:0]   hist_vals,
    output logic signed [15:0] conv_out,
    output logic               conv_valid_out,
    output logic               busy_out,
    output logic               overrun_out
);

    localparam int PAIRS = MEMORY_DEPTH / 2;
    localparam int K_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(PAIRS - 1);

    localparam logic signed [47:0] SAT_MAX = 48'sd32767;
    localparam logic signed [47:0] SAT_MIN = -48'sd32768;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SWEEP  = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [K_W-1:0]          k;
    logic [READ_LATENCY-1:0] tag_sr;
    logic                    data_valid;
    logic                    prod_tag;
    logic signed [31:0]      prod [8];
    logic signed [47:0]      lane_sum;
    logic signed [47:0]      acc;
    logic signed [47:0]      acc_shifted;
    logic signed [15:0]      sat_val;

    logic accept;
    logic abort;
    logic pipe_empty;
    logic result_load;

    // Control qualifiers shared by the FSM and the datapath.
    always_comb begin
        accept      = (state == S_IDLE) && start_in && !ir_loading_in;
        abort       = (state != S_IDLE) && ir_loading_in;
        data_valid  = tag_sr[READ_LATENCY-1];
        pipe_empty  = (tag_sr == '0) && !prod_tag;
        result_load = (state == S_DRAIN) && (state_nxt == S_OUTPUT);
    end

    // State register.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an IR reload always wins and abandons the run.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (k == K_LAST) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (pipe_empty) begin
                    // Last tagged sum has landed in acc this cycle.
                    state_nxt = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore outputs: indices only move during SWEEP, busy spans SWEEP+DRAIN.
    always_comb begin
        first_ir_index  = '0;
        second_ir_index = '0;
        busy_out        = 1'b0;
        case (state)
            S_SWEEP: begin
                first_ir_index  = 13'({k, 1'b0});
                second_ir_index = 13'({k, 1'b1});
                busy_out        = 1'b1;
            end
            S_DRAIN: begin
                busy_out = 1'b1;
            end
            default: begin
                busy_out = 1'b0;
            end
        endcase
    end

    // Pair counter; parks on the last pair so indices never run past the bank.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            k <= '0;
        end else if (accept) begin
            k <= '0;
        end else if ((state == S_SWEEP) && (k != K_LAST)) begin
            k <= k + K_W'(1);
        end
    end

    // Read-tag pipeline: marks which returning data words belong to the sweep.
    always_ff @(posedge audio_clk) begin
        if (rst_in || abort) begin
            tag_sr <= '0;
        end else begin
            tag_sr <= (tag_sr << 1) | READ_LATENCY'(state == S_SWEEP);
        end
    end

    // Product stage: eight signed 16x16 multiplies registered together.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            prod_tag <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                prod[i] <= '0;
            end
        end else if (abort) begin
            prod_tag <= 1'b0;
        end else begin
            prod_tag <= data_valid;
            if (data_valid) begin
                for (int i = 0; i < 8; i++) begin
                    prod[i] <= $signed(ir_vals[i]) * $signed(hist_vals[i]);
                end
            end
        end
    end

    // 8-way adder tree feeding the accumulator, sign-extended to 48 bits.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < 8; i++) begin
            lane_sum = lane_sum + $signed({{16{prod[i][31]}}, prod[i]});
        end
    end

    // Accumulator: cleared on a new run or abort, adds only tagged sums.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            acc <= '0;
        end else if (accept || abort) begin
            acc <= '0;
        end else if (prod_tag) begin
            acc <= acc + lane_sum;
        end
    end

    // Q-format rescale and clamp to the 16-bit output range.
    always_comb begin
        acc_shifted = acc >>> OUT_SHIFT;
        if (acc_shifted > SAT_MAX) begin
            sat_val = 16'sh7fff;
        end else if (acc_shifted < SAT_MIN) begin
            sat_val = -16'sh8000;
        end else begin
            sat_val = acc_shifted[15:0];
        end
    end

    // Result register and status pulses; conv_out holds across aborts.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            conv_out       <= '0;
            conv_valid_out <= 1'b0;
            overrun_out    <= 1'b0;
        end else begin
            conv_valid_out <= result_load;
            overrun_out    <= start_in && (state != S_IDLE);
            if (result_load) begin
                conv_out <= sat_val;
            end
        end
    end

endmodule
